controlador_divisor: RTL

CONTROLADOR_DIVISOR -- requirements
Module: controlador_divisor

---
 rtl/controlador_divisor.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/controlador_divisor.sv
// Programmable clock divider with a two-state IDLE/RUN controller and valid/ready configuration.
// Optional pulse counting is enabled by defining CONTROLADOR_DIVISOR_CONTEO_EN.
module controlador_divisor #(
    parameter int          NBITS       = 20,
    parameter int unsigned DIV_DEFAULT = 32'd300000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [NBITS-1:0] cfg_div,
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
    input  logic [7:0]       cfg_pulsos,
`endif
    input  logic             start,
    input  logic             stop,
    output logic             salida,
    output logic             tick,
    output logic             ocupado,
    output logic             fin
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } estado_t;

    estado_t          estado_q;
    logic [NBITS-1:0] count_q;
    logic [NBITS-1:0] div_q;
    logic [NBITS-1:0] pend_div_q;
    logic             pend_q;
    logic             stop_q;
    logic             salida_q;
    logic             tick_q;
    logic             fin_q;
    logic             ocupado_q;
    logic             cfg_ready_q;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
    logic [7:0]       target_q;
    logic [7:0]       pend_tgt_q;
    logic [7:0]       pcnt_q;
`endif

    logic acepta;
    logic terminal;
    logic stop_ef;
    logic limite;
    logic termina;

    // Handshake, terminal-count and end-of-generation decode
    always_comb begin
        acepta   = cfg_valid && cfg_ready_q;
        terminal = (estado_q == RUN) && (count_q == div_q);
        stop_ef  = stop_q || stop;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
        // >= also covers a new target that is already at or below the running count
        limite   = (target_q != 8'd0) && (({1'b0, pcnt_q} + 9'd1) >= {1'b0, target_q});
`else
        limite   = 1'b0;
`endif
        // Generation only ends on a falling edge, so half-periods are never truncated
        termina  = terminal && salida_q && (stop_ef || limite);
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= IDLE;
            count_q     <= '0;
            div_q       <= NBITS'(DIV_DEFAULT);
            pend_div_q  <= '0;
            pend_q      <= 1'b0;
            stop_q      <= 1'b0;
            salida_q    <= 1'b0;
            tick_q      <= 1'b0;
            fin_q       <= 1'b0;
            ocupado_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
            target_q    <= 8'd0;
            pend_tgt_q  <= 8'd0;
            pcnt_q      <= 8'd0;
`endif
        end else begin
            tick_q <= 1'b0;
            fin_q  <= 1'b0;
            case (estado_q)
                IDLE: begin
                    count_q     <= '0;
                    salida_q    <= 1'b0;
                    cfg_ready_q <= 1'b1;
                    if (acepta) begin
                        div_q <= cfg_div;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
                        target_q <= cfg_pulsos;
`endif
                    end
                    // A simultaneous stop cancels the start
                    if (start && !stop) begin
                        estado_q  <= RUN;
                        ocupado_q <= 1'b1;
                        stop_q    <= 1'b0;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
                        pcnt_q    <= 8'd0;
`endif
                    end
                end
                RUN: begin
                    if (terminal) begin
                        count_q <= '0;
                        tick_q  <= 1'b1;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
                        if (salida_q) begin
                            pcnt_q <= pcnt_q + 8'd1;
                        end
`endif
                        if (pend_q) begin
                            div_q  <= pend_div_q;
                            pend_q <= 1'b0;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
                            target_q <= pend_tgt_q;
`endif
                        end
                        if (termina) begin
                            estado_q    <= IDLE;
                            salida_q    <= 1'b0;
                            fin_q       <= 1'b1;
                            stop_q      <= 1'b0;
                            ocupado_q   <= 1'b0;
                            cfg_ready_q <= 1'b1;
                            // Back in IDLE, a configuration taken on this edge applies directly
                            if (acepta) begin
                                div_q <= cfg_div;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
                                target_q <= cfg_pulsos;
`endif
                            end
                        end else begin
                            salida_q    <= !salida_q;
                            stop_q      <= stop_ef;
                            cfg_ready_q <= !acepta;
                            if (acepta) begin
                                pend_q     <= 1'b1;
                                pend_div_q <= cfg_div;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
                                pend_tgt_q <= cfg_pulsos;
`endif
                            end
                        end
                    end else begin
                        count_q     <= count_q + NBITS'(1);
                        stop_q      <= stop_ef;
                        cfg_ready_q <= !(pend_q || acepta);
                        if (acepta) begin
                            pend_q     <= 1'b1;
                            pend_div_q <= cfg_div;
`ifdef CONTROLADOR_DIVISOR_CONTEO_EN
                            pend_tgt_q <= cfg_pulsos;
`endif
                        end
                    end
                end
                default: begin
                    estado_q  <= IDLE;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign salida    = salida_q;
    assign tick      = tick_q;
    assign ocupado   = ocupado_q;
    assign fin       = fin_q;

endmodule
